// File: rtl/fpu_pkg.sv
// Shared FPU constants: operand width, default multiplier latency and the
// owner-tag width helper used by the multiplier arbiter.
package fpu_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int LAT_DEF     = 3;
    localparam int N_DEF       = 2;

    // A tag must index N requesters; a single requester still needs one bit.
    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int TAG_W = tag_width(N_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant among eligible requesters,
// searching upward from a pointer that moves past the last winner.
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic [N-1:0] elig_i,
    output logic [N-1:0] grant_o
);

    localparam int IW = tag_width(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;

    // Walk offsets from the far end so the closest eligible requester to ptr wins.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (elig_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                ptr_d        = IW'((int'(ptr_q) + k + 1) % N);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined FP multiplier among N requesters: round-robin issue,
// a latency-matched owner tag pipe, and per-requester credit limits.
module fp_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int N       = 2,
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int LAT     = LAT_DEF,
    parameter int MAX_OUT = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*D_WIDTH-1:0] req_a,
    input  logic [N*D_WIDTH-1:0] req_b,
    output logic [N-1:0]         req_ready,
    output logic                 mul_enable,
    output logic [D_WIDTH-1:0]   mul_a,
    output logic [D_WIDTH-1:0]   mul_b,
    input  logic [D_WIDTH-1:0]   mul_result,
    output logic [N-1:0]         rsp_valid,
    output logic [D_WIDTH-1:0]   rsp_data,
    output logic                 busy
);

    localparam int IW = tag_width(N);
    localparam int CW = $clog2(MAX_OUT + 1);

    // Handshake: a pair transfers on req_valid[i] & req_ready[i]; responses
    // are one-cycle rsp_valid pulses with no backpressure.
    logic              mul_enable_q;
    logic              active;
    logic [N-1:0]      elig;
    logic [N-1:0]      grant;
    logic [IW-1:0]     gnt_idx;
    logic              tag_vld_q [LAT];
    logic [IW-1:0]     tag_own_q [LAT];
    logic [CW-1:0]     outstanding_q [N];
    logic [CW-1:0]     outstanding_d [N];
    logic              retire;
    logic              busy_any;

    // No issue until the multiplier is enabled, so every tag matches a real operation.
    assign active     = reset_n & mul_enable_q;
    assign mul_enable = mul_enable_q;
    assign retire     = reset_n & tag_vld_q[LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            rsp_valid[i] = retire && (tag_own_q[LAT-1] == IW'(i));
        end
    end

    // A retiring operation returns its credit in the same cycle it frees it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = active & req_valid[i]
                    & ((outstanding_q[i] < CW'(MAX_OUT)) | rsp_valid[i]);
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .elig_i  (elig),
        .grant_o (grant)
    );

    assign req_ready = grant;

    always_comb begin
        gnt_idx = '0;
        mul_a   = reset_n ? req_a[D_WIDTH-1:0] : '0;
        mul_b   = reset_n ? req_b[D_WIDTH-1:0] : '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gnt_idx = IW'(i);
                mul_a   = req_a[i*D_WIDTH +: D_WIDTH];
                mul_b   = req_b[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    assign rsp_data = (|rsp_valid) ? mul_result : '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            outstanding_d[i] = outstanding_q[i];
            case ({grant[i], rsp_valid[i]})
                2'b10:   outstanding_d[i] = outstanding_q[i] + CW'(1);
                2'b01:   outstanding_d[i] = outstanding_q[i] - CW'(1);
                default: outstanding_d[i] = outstanding_q[i];
            endcase
        end
    end

    always_comb begin
        busy_any = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            busy_any = busy_any | tag_vld_q[k];
        end
    end

    assign busy = reset_n & busy_any;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            mul_enable_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_own_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            mul_enable_q <= 1'b1;
            tag_vld_q[0] <= |grant;
            tag_own_q[0] <= gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_own_q[k] <= tag_own_q[k-1];
            end
            for (int i = 0; i < N; i++) begin
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

endmodule
